// File: rtl/x_rst_seq_pkg.sv
// Shared types and sizing helpers for the PLL-lock reset sequencer.
package x_rst_seq_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } t_rst_seq_state;

    localparam int LP_STATE_W = 3;

    // One counter serves every phase, so it is sized for the longest of them.
    function automatic int f_cnt_width(
        input int pll_rst_cyc,
        input int stable_cyc,
        input int timeout_cyc,
        input int stagger_cyc
    );
        int max_cyc;
        max_cyc = pll_rst_cyc;
        max_cyc = (stable_cyc  > max_cyc) ? stable_cyc  : max_cyc;
        max_cyc = (timeout_cyc > max_cyc) ? timeout_cyc : max_cyc;
        max_cyc = (stagger_cyc > max_cyc) ? stagger_cyc : max_cyc;
        return $clog2(max_cyc) + 1;
    endfunction

endpackage

// File: rtl/x_rst_seq_if.sv
// Bundle of PLL-side and downstream reset signals handled by the sequencer.
interface x_rst_seq_if #(
    parameter int p_n_dom   = 2,
    parameter int p_retry_w = 4
);
    logic                 i_lock;
    logic                 o_pll_resetb;
    logic [p_n_dom-1:0]   o_rst;
    logic                 o_ready;
    logic [p_retry_w-1:0] o_retry_cnt;

    modport master (
        input  i_lock,
        output o_pll_resetb,
        output o_rst,
        output o_ready,
        output o_retry_cnt
    );

    modport slave (
        output i_lock,
        input  o_pll_resetb,
        input  o_rst,
        input  o_ready,
        input  o_retry_cnt
    );
endinterface

// File: rtl/x_rst_seq_chk.sv
// Properties on the downstream reset vector: ordered one-at-a-time release,
// all-together assertion, and ready only with every domain released.
module x_rst_seq_chk #(
    parameter int p_n_dom = 2
) (
    input logic               i_clk,
    input logic               i_nrst,
    input logic [p_n_dom-1:0] i_rst,
    input logic               i_ready
);
    a_one_release: assert property (@(posedge i_clk) disable iff (!i_nrst)
        $onehot0($past(i_rst) & ~i_rst));

    a_ascending: assert property (@(posedge i_clk) disable iff (!i_nrst)
        (($past(i_rst) & ~i_rst) != '0) |->
        ((((($past(i_rst) & ~i_rst)) - p_n_dom'(1)) & i_rst) == '0));

    a_assert_all: assert property (@(posedge i_clk) disable iff (!i_nrst)
        ((~$past(i_rst) & i_rst) != '0) |-> (i_rst == '1));

    a_ready: assert property (@(posedge i_clk) disable iff (!i_nrst)
        i_ready |-> (i_rst == '0));

endmodule

// File: rtl/x_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module x_sync_bit #(
    parameter int p_depth = 2
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_d,
    output logic o_q
);
    logic [p_depth-1:0] sync_q;
    logic [p_depth-1:0] sync_d;

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[p_depth-2:0], i_d};
    end

    // Synchroniser stages.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[p_depth-1];

endmodule

// File: rtl/x_rst_seq.sv
// Power-up / PLL-lock reset sequencer: pulses PLL RESETB, waits for a stable
// lock with timeout and retry, then releases downstream resets in order.
module x_rst_seq
    import x_rst_seq_pkg::*;
#(
    parameter int p_n_dom       = 2,
    parameter int p_pll_rst_cyc = 16,
    parameter int p_stable_cyc  = 1200,
    parameter int p_timeout_cyc = 120000,
    parameter int p_stagger_cyc = 8,
    parameter int p_sync        = 2,
    parameter int p_retry_w     = 4
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    x_rst_seq_if.master bus
);
    localparam int CNT_W = f_cnt_width(p_pll_rst_cyc, p_stable_cyc, p_timeout_cyc, p_stagger_cyc);
    localparam int IDX_W = (p_n_dom > 1) ? $clog2(p_n_dom) : 1;

    localparam logic [CNT_W-1:0]     PLL_LAST  = CNT_W'(p_pll_rst_cyc - 1);
    localparam logic [CNT_W-1:0]     TMO_LAST  = CNT_W'(p_timeout_cyc - 1);
    localparam logic [CNT_W-1:0]     STB_LAST  = CNT_W'(p_stable_cyc - 1);
    localparam logic [CNT_W-1:0]     STG_LAST  = CNT_W'(p_stagger_cyc - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(p_n_dom - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
    localparam logic [p_n_dom-1:0]   DOM_ONE   = p_n_dom'(1);
    localparam logic [p_retry_w-1:0] RETRY_MAX = '1;
    localparam logic [p_retry_w-1:0] RETRY_ONE = p_retry_w'(1);

    logic                       lock_s;
    logic [LP_STATE_W-1:0]      state_q;
    logic [LP_STATE_W-1:0]      state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           idx_d;
    logic [p_n_dom-1:0]         rst_q;
    logic [p_n_dom-1:0]         rst_d;
    logic                       pll_resetb_q;
    logic                       pll_resetb_d;
    logic                       ready_q;
    logic                       ready_d;
    logic [p_retry_w-1:0]       retry_q;
    logic [p_retry_w-1:0]       retry_d;

    x_sync_bit #(
        .p_depth (p_sync)
    ) u_lock_sync (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_d    (bus.i_lock),
        .o_q    (lock_s)
    );

    // Sequencer next-state, shared counter and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        retry_d = retry_q;
        ready_d = 1'b0;

        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    if (retry_q != RETRY_MAX) begin
                        retry_d = retry_q + RETRY_ONE;
                    end else begin
                        retry_d = retry_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A single dropped sample restarts the wait without counting a retry.
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Each domain is released when the stagger counter wraps to zero.
            S_RELEASE: begin
                if (!lock_s) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                end else begin
                    if (cnt_q == '0) begin
                        rst_d = rst_q & ~(DOM_ONE << idx_q);
                    end else begin
                        rst_d = rst_q;
                    end
                    if ((cnt_q == '0) && (idx_q == IDX_LAST)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == STG_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + IDX_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                end else begin
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
                idx_d   = '0;
                rst_d   = '1;
            end
        endcase

        pll_resetb_d = (state_d != S_PLL_RST);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= S_PLL_RST;
            cnt_q        <= '0;
            idx_q        <= '0;
            rst_q        <= '1;
            pll_resetb_q <= 1'b0;
            ready_q      <= 1'b0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rst_q        <= rst_d;
            pll_resetb_q <= pll_resetb_d;
            ready_q      <= ready_d;
            retry_q      <= retry_d;
        end
    end

    assign bus.o_pll_resetb = pll_resetb_q;
    assign bus.o_rst        = rst_q;
    assign bus.o_ready      = ready_q;
    assign bus.o_retry_cnt  = retry_q;

endmodule
